// File: rtl/reg_alu_ctrl_pkg.sv
// rtl/reg_alu_ctrl_pkg.sv - shared encodings for the reg_alu command sequencer
package reg_alu_ctrl_pkg;

  localparam logic [1:0] KIND_LOAD = 2'b00;
  localparam logic [1:0] KIND_ALU  = 2'b01;
  localparam logic [1:0] KIND_READ = 2'b10;
  localparam logic [1:0] KIND_NOP  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/reg_alu_ctrl.sv
// rtl/reg_alu_ctrl.sv - command sequencer driving the reg_alu register file and ALU
module reg_alu_ctrl
  import reg_alu_ctrl_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_kind,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [AW-1:0] cmd_rd,
  input  logic [DW-1:0] cmd_imm,
  input  logic [RW-1:0] cmd_rpt,
  output logic          sel,
  output logic          wr,
  output logic [1:0]    op,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] d_in,
  input  logic [DW-1:0] d_out_a,
  input  logic [DW-1:0] d_out_b,
  input  logic          cout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data_a,
  output logic [DW-1:0] rsp_data_b,
  output logic          rsp_cout,
  output logic          flag_c,
  output logic [CW-1:0] retired,
  output logic          busy
);

  state_t        r_state;
  logic [1:0]    r_kind;
  logic [1:0]    r_op;
  logic [AW-1:0] r_ra;
  logic [AW-1:0] r_rb;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_imm;
  logic [RW-1:0] r_rpt_cnt;
  logic          r_flag_c;
  logic [DW-1:0] r_rsp_a;
  logic [DW-1:0] r_rsp_b;
  logic          r_rsp_cout;
  logic [CW-1:0] r_retired;

  state_t        w_next_state;
  logic          w_retire;

  // Every pin toward reg_alu is decoded from registered state only, never from cmd_*.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    sel          = 1'b0;
    wr           = 1'b0;
    op           = 2'b00;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    wr_addr      = '0;
    d_in         = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next_state = ST_EXEC;
      end
      ST_EXEC: begin
        case (r_kind)
          KIND_LOAD: begin
            wr           = 1'b1;
            wr_addr      = r_rd;
            d_in         = r_imm;
            w_next_state = ST_IDLE;
          end
          KIND_ALU: begin
            wr        = 1'b1;
            sel       = 1'b1;
            op        = r_op;
            rd_addr_a = r_ra;
            rd_addr_b = r_rb;
            wr_addr   = r_rd;
            if (r_rpt_cnt == '0) w_next_state = ST_IDLE;
          end
          KIND_READ: begin
            rd_addr_a    = r_ra;
            rd_addr_b    = r_rb;
            w_next_state = ST_RESP;
          end
          default: w_next_state = ST_IDLE;
        endcase
        w_retire = (w_next_state == ST_IDLE);
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
          w_retire     = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_kind     <= KIND_LOAD;
      r_op       <= 2'b00;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_rpt_cnt  <= '0;
      r_flag_c   <= 1'b0;
      r_rsp_a    <= '0;
      r_rsp_b    <= '0;
      r_rsp_cout <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_retired <= r_retired + CW'(1);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_kind    <= cmd_kind;
            r_op      <= cmd_op;
            r_ra      <= cmd_ra;
            r_rb      <= cmd_rb;
            r_rd      <= cmd_rd;
            r_imm     <= cmd_imm;
            r_rpt_cnt <= cmd_rpt;
          end
        end
        ST_EXEC: begin
          if (r_kind == KIND_ALU) begin
            r_flag_c <= cout;
            if (r_rpt_cnt != '0) r_rpt_cnt <= r_rpt_cnt - RW'(1);
          end
          if (r_kind == KIND_READ) begin
            r_rsp_a    <= d_out_a;
            r_rsp_b    <= d_out_b;
            r_rsp_cout <= r_flag_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_data_a = r_rsp_a;
  assign rsp_data_b = r_rsp_b;
  assign rsp_cout   = r_rsp_cout;
  assign flag_c     = r_flag_c;
  assign retired    = r_retired;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/reg_alu_ctrl.md
# reg_alu_ctrl

Command sequencer for the `reg_alu` datapath (8×16 register file plus 2-bit-op ALU with carry-out).
- Accepts one command at a time over a valid/ready handshake: LOAD, ALU, READ or NOP.
- Drives the `reg_alu` control and address pins cycle by cycle, including multi-cycle repeated ALU operations.
- Returns READ results over a response handshake.
- Sits between the host/stimulus side and the `reg_alu` instance inside the `reg_alu_sys` wrapper.

## Interface
- `DW` = 16: datapath width
- `AW` = 3: register address width (8 registers)
- `RW` = 3: repeat-count width
- `CW` = 16: retired-command counter width

Clock and reset:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset

Command channel:
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_kind`  in  2  00 LOAD, 01 ALU, 10 READ, 11 NOP
- `cmd_op`  in  2  ALU op, passed through to `op`
- `cmd_ra`, `cmd_rb`  in  AW  source registers
- `cmd_rd`  in  AW  destination register
- `cmd_imm`  in  DW  LOAD immediate
- `cmd_rpt`  in  RW  ALU executes `cmd_rpt`+1 times

Outputs to `reg_alu`:
- `sel`  out  1  1 = write ALU result, 0 = write `d_in`
- `wr`  out  1  register-file write enable
- `op`  out  2  ALU op
- `rd_addr_a`, `rd_addr_b`  out  AW  read addresses
- `wr_addr`  out  AW  write address
- `d_in`  out  DW  write data for LOAD

Inputs from `reg_alu`:
- `d_out_a`, `d_out_b`  in  DW  combinational read data
- `cout`  in  1  ALU carry-out

Response channel and status:
- `rsp_valid`  out  1  READ result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_data_a`, `rsp_data_b`  out  DW  captured read data
- `rsp_cout`  out  1  carry flag at the time of capture
- `flag_c`  out  1  carry of the last ALU execution
- `retired`  out  CW  count of completed commands (wraps)
- `busy`  out  1  state ≠ IDLE

## Operation

States: IDLE, EXEC, RESP.

**IDLE**
- `cmd_ready`=1.
- When `cmd_valid`&`cmd_ready`: latch all `cmd_*` fields, load `rpt_cnt`=`cmd_rpt`, go to EXEC.

**EXEC** (fields are driven from the latched copy)
- LOAD: `wr`=1, `sel`=0, `wr_addr`=rd, `d_in`=imm. One cycle, then IDLE.
- ALU: `wr`=1, `sel`=1, `op`, `rd_addr_a`=ra, `rd_addr_b`=rb, `wr_addr`=rd.
  - `flag_c`←`cout` at the end of every ALU EXEC cycle.
  - If `rpt_cnt`≠0: decrement it and stay in EXEC. Otherwise go to IDLE.
  - With rd==ra, each repeat consumes the value written by the previous one (accumulation).
- READ: `wr`=0, read addresses driven. `rsp_data_a/b`←`d_out_a/b` and `rsp_cout`←`flag_c` at the end of the cycle, then RESP.
- NOP: `wr`=0 for one cycle, then IDLE.

**RESP**
- `rsp_valid`=1; response registers are held stable.
- On `rsp_ready`: go to IDLE.

**General rules**
- `cmd_rpt` is ignored for every kind except ALU.
- `retired` increments once per command, on the cycle it leaves EXEC (LOAD/ALU/NOP) or RESP (READ). Repeats do not count individually. Wraps modulo 2^CW.
- Outside EXEC: `wr`=0, `sel`=0, `op`=0, all addresses=0, `d_in`=0.

## Timing
- Reset (asynchronous): state=IDLE, all outputs 0, including `flag_c`, `retired` and `rsp_*`. `wr` drops immediately, even mid-EXEC.
  - A reset during RESP discards the pending response.
  - A reset during a repeat aborts the remaining repeats. Writes already completed stand.
- Control outputs are decoded from the registered state and latched fields (glitch-free with respect to `cmd_*`).
- `cmd_*` may change freely while `cmd_ready`=0.
- Latency from command acceptance:
  - LOAD/NOP: write (if any) at the 2nd edge. Next accept at the 2nd edge.
  - ALU: N=`cmd_rpt`+1 writes at edges 2..N+1.
  - READ: `rsp_valid` from edge 2 until accepted.
- Maximum throughput: one command per 2 cycles.
- `rsp_valid` does not depend on `rsp_ready` combinationally.
- `cmd_ready` is never asserted in the same cycle as `rsp_valid`.

## Structure
- `reg_alu_ctrl_pkg`: `cmd_kind` encodings (KIND_LOAD/ALU/READ/NOP), the state enum, and op constants (OP_ADD=2'b00, …) shared with `reg_alu`.
- Single flat module with no sub-modules. The `reg_alu` instance lives in `reg_alu_sys` next to the controller.
- Benches instantiate `reg_alu_sys`.

## Test plan
- **Reset:** hold `reset`=0 for 12.5 ns → all outputs 0, `cmd_ready`=1. Assert `reset`=0 mid-EXEC → `wr`=0 before the next edge.
- **Load/add/read:** LOAD r3=16'hcdef; LOAD r7=16'h3210; ALU add r1=r3+r7; READ ra=r1, rb=r3 → `rsp_data_a`=16'hffff, `rsp_data_b`=16'hcdef, `rsp_cout`=0, `retired`=4.
- **Carry:** LOAD r2=16'hffff; LOAD r4=16'h0001; ALU add r5=r2+r4; READ r5 → `rsp_data_a`=16'h0000, `rsp_cout`=1, `flag_c`=1.
- **Repeat:** LOAD r6=16'h0003; ALU add rd=ra=rb=r6 with `cmd_rpt`=2 → 3 consecutive `wr` cycles; READ r6 → 16'h0018; `retired` increments by 2 in total (ALU command plus READ).
- **Backpressure:** READ with `rsp_ready`=0 for 5 cycles → `rsp_valid` and data held stable, `cmd_ready`=0. `rsp_ready`=1 → IDLE next edge.
- **Abort:** reset asserted during the 2nd repeat of a `cmd_rpt`=3 ALU command → only the 1st write has occurred; after reset, state=IDLE with `retired`=0.
